// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 4-slot TDM receive path.
package tdm_pkg;
  localparam int TDM_SLOTS  = 4;
  localparam int TDM_SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter; load0 means the current sample is slot 0, so the next one is slot 1.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load0,
  output logic [TDM_SLOT_W-1:0] slot
);

  logic [TDM_SLOT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load0)   cnt_d = TDM_SLOT_W'(1);
    else if (en) cnt_d = cnt_q + TDM_SLOT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign slot = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: aligns on frame_sync and publishes whole frames atomically.
// TDM_DEMUX4_STICKY_ERR_EN defined makes sync_err sticky until reset; otherwise it pulses.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic             out_valid,
  output logic             locked,
  output logic             sync_err
);

  // state  | meaning
  // HUNT   | waiting for a valid frame_sync sample to align on slot 0
  // LOCKED | aligned; slots captured by the free-running slot counter

  tdm_state_t state_q, state_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] y1_q, y1_d, y2_q, y2_d, y3_q, y3_d, y4_q, y4_d;
  logic out_valid_q, out_valid_d;
  logic sync_err_q, sync_err_d;
  logic ctr_en, ctr_load0;
  logic [TDM_SLOT_W-1:0] slot;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (ctr_en),
    .load0 (ctr_load0),
    .slot  (slot)
  );

  always_comb begin
    state_d     = state_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    y3_d        = y3_q;
    y4_d        = y4_q;
    out_valid_d = 1'b0;
    ctr_en      = 1'b0;
    ctr_load0   = 1'b0;
`ifdef TDM_DEMUX4_STICKY_ERR_EN
    sync_err_d  = sync_err_q;
`else
    sync_err_d  = 1'b0;
`endif
    case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          sh0_d     = din;
          ctr_load0 = 1'b1;
          state_d   = LOCKED;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          // A sync away from slot 0 realigns and drops the partial frame.
          if (frame_sync && (slot != '0)) begin
            sh0_d      = din;
            ctr_load0  = 1'b1;
            sync_err_d = 1'b1;
          end else begin
            ctr_en = 1'b1;
            case (slot)
              2'd0: sh0_d = din;
              2'd1: sh1_d = din;
              2'd2: sh2_d = din;
              default: begin
                y1_d        = sh0_q;
                y2_d        = sh1_q;
                y3_d        = sh2_q;
                y4_d        = din;
                out_valid_d = 1'b1;
              end
            endcase
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      y3_q        <= '0;
      y4_q        <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      y3_q        <= y3_d;
      y4_q        <= y4_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign y1        = y1_q;
  assign y2        = y2_q;
  assign y3        = y3_q;
  assign y4        = y4_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == LOCKED);
  assign sync_err  = sync_err_q;

endmodule
